// File: rtl/wb_trace_pkg.sv
// Shared types and constants for the write-back trace FIFO.
// The entry carries a capture timestamp only when WB_TRACE_TSTAMP_EN is defined.
package wb_trace_pkg;
  localparam int DEPTH  = 16;
  localparam int DATA_W = 32;
  localparam int RD_W   = 5;
  localparam int OVF_W  = 16;
  localparam int TS_W   = 32;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [OVF_W-1:0] OVF_SAT = '1;

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
`ifdef WB_TRACE_TSTAMP_EN
    logic [TS_W-1:0]   tstamp;
`endif
  } wb_trace_entry_t;

  // The drop counter sticks at all-ones so a reader never sees a small, wrapped value.
  function automatic logic [OVF_W-1:0] ovf_inc(input logic [OVF_W-1:0] cnt);
    return (cnt == OVF_SAT) ? cnt : cnt + OVF_W'(1);
  endfunction
endpackage

// File: rtl/wb_trace_ptr.sv
// Read/write pointers and occupancy for a power-of-two FIFO; pointers wrap naturally.
// Count and flags are registered from the next-state count; no input-to-flag path.
module wb_trace_ptr #(
  parameter int  DEPTH = 16,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic          i_pop,
  output logic [PW-1:0] o_wr_ptr,
  output logic [PW-1:0] o_rd_ptr,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;
  logic [CW-1:0] w_cnt_nxt;

  assign w_cnt_nxt = r_count + CW'(i_push) - CW'(i_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == CW'(DEPTH));
      r_empty <= (w_cnt_nxt == '0);
    end
  end

  assign o_wr_ptr = r_wr_ptr;
  assign o_rd_ptr = r_rd_ptr;
  assign o_count  = r_count;
  assign o_full   = r_full;
  assign o_empty  = r_empty;
endmodule

// File: rtl/wb_trace_fifo.sv
// FWFT trace FIFO of retired register writes (x0 ignored); push visible at head one cycle later.
// Captures arriving while full with no pop are dropped and counted; WB_TRACE_TSTAMP_EN adds cycle stamps.
module wb_trace_fifo
  import wb_trace_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [RD_W-1:0]   wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RD_W-1:0]   out_rd,
  output logic [DATA_W-1:0] out_data,
`ifdef WB_TRACE_TSTAMP_EN
  output logic [TS_W-1:0]   out_tstamp,
`endif
  output logic [CNT_W-1:0]  fifo_count,
  output logic              full,
  output logic              empty,
  output logic [OVF_W-1:0]  ovf_count
);
  wb_trace_entry_t r_mem [DEPTH];
  logic [OVF_W-1:0] r_ovf_count;
  logic [PTR_W-1:0] w_wr_ptr;
  logic [PTR_W-1:0] w_rd_ptr;
  logic             w_cap;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  wb_trace_entry_t  w_wr_entry;
  wb_trace_entry_t  w_head;

  // A pop frees the slot this same edge, so a full FIFO can still accept.
  assign w_cap  = wb_valid && (wb_rd != '0);
  assign w_pop  = out_valid && out_ready;
  assign w_push = w_cap && (!full || w_pop);
  assign w_drop = w_cap && full && !w_pop;

  wb_trace_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk      (clk),
    .reset    (reset),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .o_wr_ptr (w_wr_ptr),
    .o_rd_ptr (w_rd_ptr),
    .o_count  (fifo_count),
    .o_full   (full),
    .o_empty  (empty)
  );

`ifdef WB_TRACE_TSTAMP_EN
  logic [TS_W-1:0] r_tstamp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_tstamp <= '0;
    else        r_tstamp <= r_tstamp + TS_W'(1);
  end
`endif

  always_comb begin
    w_wr_entry      = '0;
    w_wr_entry.rd   = wb_rd;
    w_wr_entry.data = wb_data;
`ifdef WB_TRACE_TSTAMP_EN
    w_wr_entry.tstamp = r_tstamp;
`endif
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[w_wr_ptr] <= w_wr_entry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_ovf_count <= '0;
    else if (w_drop) r_ovf_count <= ovf_inc(r_ovf_count);
  end

  assign w_head    = r_mem[w_rd_ptr];
  assign out_valid = !empty;
  assign out_rd    = w_head.rd;
  assign out_data  = w_head.data;
`ifdef WB_TRACE_TSTAMP_EN
  assign out_tstamp = w_head.tstamp;
`endif
  assign ovf_count = r_ovf_count;
endmodule

// File: tb/tb_wb_trace_fifo.sv
// Bench for wb_trace_fifo: directed table, corner sequences and a queue-based reference model.
module tb_wb_trace_fifo;
  import wb_trace_pkg::*;

  logic              clk;
  logic              reset;
  logic              wb_valid;
  logic [RD_W-1:0]   wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [RD_W-1:0]   out_rd;
  logic [DATA_W-1:0] out_data;
`ifdef WB_TRACE_TSTAMP_EN
  logic [TS_W-1:0]   out_tstamp;
`endif
  logic [CNT_W-1:0]  fifo_count;
  logic              full;
  logic              empty;
  logic [OVF_W-1:0]  ovf_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t             q[$];
  logic [OVF_W-1:0] drops;

  typedef struct {
    logic              v;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
    logic              rdy;
    int                exp_cnt;
    logic [RD_W-1:0]   exp_head;
  } vec_t;

  vec_t tbl[9];

  wb_trace_fifo dut (
    .clk        (clk),
    .reset      (reset),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rd     (out_rd),
    .out_data   (out_data),
`ifdef WB_TRACE_TSTAMP_EN
    .out_tstamp (out_tstamp),
`endif
    .fifo_count (fifo_count),
    .full       (full),
    .empty      (empty),
    .ovf_count  (ovf_count)
  );

  initial begin
    clk = 1'b0;
    #2;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".count"}, 64'(fifo_count), 64'(q.size()));
    chk({tag, ".full"}, 64'(full), 64'(q.size() == DEPTH));
    chk({tag, ".empty"}, 64'(empty), 64'(q.size() == 0));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() != 0));
    chk({tag, ".ovf"}, 64'(ovf_count), 64'(drops));
    if (q.size() != 0) begin
      chk({tag, ".head_rd"}, 64'(out_rd), 64'(q[0].rd));
      chk({tag, ".head_data"}, 64'(out_data), 64'(q[0].data));
    end
  endtask

  // One clock of stimulus; the model applies the capture/drop rules to its own queue.
  task automatic cyc(input logic v, input logic [RD_W-1:0] rd, input logic [DATA_W-1:0] d,
                     input logic rdy, input string tag);
    bit pop;
    bit cap;
    bit push;
    ent_t e;
    wb_valid  = v;
    wb_rd     = rd;
    wb_data   = d;
    out_ready = rdy;
    pop  = (q.size() > 0) && rdy;
    cap  = v && (rd != 0);
    push = cap && ((q.size() < DEPTH) || pop);
    step();
    if (pop) void'(q.pop_front());
    if (push) begin
      e.rd   = rd;
      e.data = d;
      q.push_back(e);
    end else if (cap && drops != OVF_SAT) begin
      drops = drops + 1'b1;
    end
    wb_valid  = 1'b0;
    out_ready = 1'b0;
    compare_model(tag);
  endtask

  initial begin
    reset     = 1'b0;
    wb_valid  = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;
    out_ready = 1'b0;
    drops     = '0;

    tbl[0] = '{1'b1, 5'd3,  32'h0000_000A, 1'b0, 1, 5'd3};
    tbl[1] = '{1'b1, 5'd0,  32'h0000_FFFF, 1'b0, 1, 5'd3};
    tbl[2] = '{1'b1, 5'd7,  32'h0000_000B, 1'b1, 1, 5'd7};
    tbl[3] = '{1'b0, 5'd0,  32'h0,         1'b1, 0, 5'd0};
    tbl[4] = '{1'b0, 5'd0,  32'h0,         1'b1, 0, 5'd0};
    tbl[5] = '{1'b1, 5'd9,  32'h0000_0009, 1'b1, 1, 5'd9};
    tbl[6] = '{1'b1, 5'd10, 32'h0000_0010, 1'b0, 2, 5'd9};
    tbl[7] = '{1'b0, 5'd0,  32'h0,         1'b1, 1, 5'd10};
    tbl[8] = '{1'b0, 5'd0,  32'h0,         1'b1, 0, 5'd0};

    #25;
    reset = 1'b1;
    chk("rst.empty", 64'(empty), 64'd1);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.count", 64'(fifo_count), 64'd0);
    chk("rst.ovf", 64'(ovf_count), 64'd0);
    chk("rst.full", 64'(full), 64'd0);

    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
    step();
    wb_valid = 1'b0;
    chk("single.out_valid", 64'(out_valid), 64'd1);
    chk("single.out_rd", 64'(out_rd), 64'd5);
    chk("single.out_data", 64'(out_data), 64'hDEAD_BEEF);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("single.empty", 64'(empty), 64'd1);

    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
    step();
    wb_valid = 1'b0;
    chk("x0.count", 64'(fifo_count), 64'd0);
    chk("x0.ovf", 64'(ovf_count), 64'd0);

    for (int i = 0; i < 9; i++) begin
      wb_valid = tbl[i].v; wb_rd = tbl[i].rd; wb_data = tbl[i].data; out_ready = tbl[i].rdy;
      step();
      chk($sformatf("tbl%0d.count", i), 64'(fifo_count), 64'(tbl[i].exp_cnt));
      chk($sformatf("tbl%0d.empty", i), 64'(empty), 64'(tbl[i].exp_cnt == 0));
      if (tbl[i].exp_cnt > 0) chk($sformatf("tbl%0d.head", i), 64'(out_rd), 64'(tbl[i].exp_head));
    end
    wb_valid = 1'b0; out_ready = 1'b0;
    chk("tbl.ovf", 64'(ovf_count), 64'd0);

    for (int i = 1; i <= 20; i++) begin
      wb_valid = 1'b1; wb_rd = RD_W'(i); wb_data = 32'hA000_0000 + i;
      step();
    end
    wb_valid = 1'b0;
    chk("ovf.full", 64'(full), 64'd1);
    chk("ovf.count", 64'(fifo_count), 64'd16);
    chk("ovf.ovf", 64'(ovf_count), 64'd4);
    step();
    chk("hold.out_rd", 64'(out_rd), 64'd1);
    chk("hold.out_data", 64'(out_data), 64'hA000_0001);
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("drain%0d.rd", i), 64'(out_rd), 64'(i));
      chk($sformatf("drain%0d.data", i), 64'(out_data), 64'(32'hA000_0000 + i));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    chk("drain.empty", 64'(empty), 64'd1);
    chk("drain.out_valid", 64'(out_valid), 64'd0);

    drops = 16'd4;
    for (int i = 1; i <= 16; i++) cyc(1'b1, RD_W'(i), $urandom, 1'b0, "fill");
    cyc(1'b1, 5'd21, 32'h2121_2121, 1'b1, "fullpp");
    chk("fullpp.count", 64'(fifo_count), 64'd16);
    chk("fullpp.ovf", 64'(ovf_count), 64'd4);
    chk("fullpp.head", 64'(out_rd), 64'd2);
    chk("fullpp.tail", 64'(q[DEPTH-1].rd), 64'd21);

    for (int i = 0; i < 240; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), RD_W'($urandom_range(0, 31)), $urandom,
          (i < 120) ? 1'($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 3) != 0), "rnd");
    end

    for (int i = 1; i <= 8; i++) cyc(1'b1, RD_W'(i), $urandom, 1'b0, "pre");
    out_ready = 1'b1;
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    out_ready = 1'b0;
    chk("midrst.empty", 64'(empty), 64'd1);
    chk("midrst.count", 64'(fifo_count), 64'd0);
    chk("midrst.out_valid", 64'(out_valid), 64'd0);
    chk("midrst.ovf", 64'(ovf_count), 64'd0);
    q.delete();
    drops = '0;
    #20;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      compare_model("idle");
    end
    cyc(1'b1, 5'd17, 32'hCAFE_0017, 1'b0, "postrst");
    chk("postrst.head", 64'(out_rd), 64'd17);
`ifdef WB_TRACE_TSTAMP_EN
    chk("postrst.tstamp", 64'(out_tstamp), 64'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
